// File: rtl/async_fifo_wr.sv
// Write-domain pointer/flag logic of an async FIFO: memory write strobe/address, Gray pointer export,
// full/almost-full/level from the synchronized read pointer, sticky overflow. Write strobe same cycle; flags registered.
module async_fifo_wr #(
  parameter int BUS_WIDTH = 4,
  parameter int AF_THRESH = 6
) (
  input  logic                 W_CLK,
  input  logic                 W_RST,
  input  logic                 W_INC_EN,
  input  logic                 W_OVF_CLR,
  input  logic [BUS_WIDTH-1:0] syn_gray_R_ptr,
  output logic                 W_WR_EN,
  output logic [BUS_WIDTH-2:0] W_addr,
  output logic [BUS_WIDTH-1:0] gray_W_ptr,
  output logic                 W_FULL,
  output logic                 W_ALMOST_FULL,
  output logic [BUS_WIDTH-1:0] W_LEVEL,
  output logic                 W_OVERFLOW
);

  localparam logic [BUS_WIDTH-1:0] AF_LVL = AF_THRESH[BUS_WIDTH-1:0];

  logic [BUS_WIDTH-1:0] bin_ptr;
  logic [BUS_WIDTH-1:0] bin_next;
  logic [BUS_WIDTH-1:0] gray_next;
  logic [BUS_WIDTH-1:0] rbin;
  logic [BUS_WIDTH-1:0] lvl_next;
  logic [BUS_WIDTH-1:0] full_ptr;
  logic                 accept;

  // Reset gating keeps the strobe low while the pointer is held at zero.
  assign accept    = W_INC_EN & ~W_FULL & ~W_RST;
  assign W_WR_EN   = accept;
  assign W_addr    = bin_ptr[BUS_WIDTH-2:0];
  assign bin_next  = bin_ptr + {{(BUS_WIDTH-1){1'b0}}, accept};
  assign gray_next = bin_next ^ (bin_next >> 1);
  assign full_ptr  = {~syn_gray_R_ptr[BUS_WIDTH-1:BUS_WIDTH-2], syn_gray_R_ptr[BUS_WIDTH-3:0]};
  assign lvl_next  = bin_next - rbin;

  always_comb begin
    rbin = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      rbin[i] = ^(syn_gray_R_ptr >> i);
    end
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      bin_ptr       <= '0;
      gray_W_ptr    <= '0;
      W_FULL        <= 1'b0;
      W_ALMOST_FULL <= 1'b0;
      W_LEVEL       <= '0;
      W_OVERFLOW    <= 1'b0;
    end else begin
      bin_ptr       <= bin_next;
      gray_W_ptr    <= gray_next;
      W_FULL        <= (gray_next == full_ptr);
      W_ALMOST_FULL <= (lvl_next >= AF_LVL);
      W_LEVEL       <= lvl_next;
      // A rejected write takes priority over a clear in the same cycle.
      if (W_INC_EN && W_FULL) begin
        W_OVERFLOW <= 1'b1;
      end else if (W_OVF_CLR) begin
        W_OVERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_wr.sv
// Directed bench for async_fifo_wr: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_async_fifo_wr;

  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b1;
  logic       W_INC_EN = 1'b0;
  logic       W_OVF_CLR = 1'b0;
  logic [3:0] syn_gray_R_ptr = 4'b0000;
  logic       W_WR_EN;
  logic [2:0] W_addr;
  logic [3:0] gray_W_ptr;
  logic       W_FULL;
  logic       W_ALMOST_FULL;
  logic [3:0] W_LEVEL;
  logic       W_OVERFLOW;

  async_fifo_wr #(.BUS_WIDTH(4), .AF_THRESH(6)) dut (
    .W_CLK(W_CLK),
    .W_RST(W_RST),
    .W_INC_EN(W_INC_EN),
    .W_OVF_CLR(W_OVF_CLR),
    .syn_gray_R_ptr(syn_gray_R_ptr),
    .W_WR_EN(W_WR_EN),
    .W_addr(W_addr),
    .gray_W_ptr(gray_W_ptr),
    .W_FULL(W_FULL),
    .W_ALMOST_FULL(W_ALMOST_FULL),
    .W_LEVEL(W_LEVEL),
    .W_OVERFLOW(W_OVERFLOW)
  );

  always #5 W_CLK = ~W_CLK;

  typedef struct {
    int         id;
    logic       wr;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  event chk_ev;
  int   total = 0;
  int   bad = 0;
  int   sid = 0;

  function automatic logic [3:0] g(input logic [3:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input int id, input string f, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL step%0d %s got=%0h want=%0h", id, f, act, want);
    end
  endtask

  // One cycle: drive inputs shortly after the rising edge and queue what the
  // DUT must show at the following falling edge.
  task automatic cyc(input logic rst, input logic inc, input logic clr, input logic [3:0] rp,
                     input logic wr, input logic [2:0] ad, input logic [3:0] gr,
                     input logic fu, input logic af, input logic [3:0] lv, input logic ov);
    exp_t x;
    @(posedge W_CLK);
    #2;
    W_RST = rst;
    W_INC_EN = inc;
    W_OVF_CLR = clr;
    syn_gray_R_ptr = rp;
    sid++;
    x = '{sid, wr, ad, gr, fu, af, lv, ov};
    q.push_back(x);
  endtask

  always @(negedge W_CLK or chk_ev) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.id, "wr_en", {3'b0, W_WR_EN}, {3'b0, e.wr});
      chk(e.id, "addr", {1'b0, W_addr}, {1'b0, e.addr});
      chk(e.id, "gray", gray_W_ptr, e.gray);
      chk(e.id, "full", {3'b0, W_FULL}, {3'b0, e.full});
      chk(e.id, "almost_full", {3'b0, W_ALMOST_FULL}, {3'b0, e.af});
      chk(e.id, "level", W_LEVEL, e.lvl);
      chk(e.id, "overflow", {3'b0, W_OVERFLOW}, {3'b0, e.ovf});
    end
  end

  always @(negedge W_CLK) begin
    if (!W_RST) chk(-1, "level_range", {3'b0, (W_LEVEL <= 4'd8)}, 4'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] b;
    exp_t z;
    // held in reset with a write request: nothing moves
    cyc(1, 1, 0, 4'b0000, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);
    // five accepted writes, sixth in flight
    for (int i = 0; i < 6; i++) begin
      b = 4'(i);
      cyc(0, 1, 0, 4'b0000, 1, b[2:0], g(b), 0, 0, b, 0);
    end
    // asynchronous reset mid-cycle with the pointer at 5
    @(negedge W_CLK);
    #2;
    W_RST = 1'b1;
    #1;
    sid++;
    z = '{sid, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0};
    q.push_back(z);
    -> chk_ev;
    // fill from zero after release; first write must go to address 0
    for (int i = 0; i < 8; i++) begin
      b = 4'(i);
      cyc(0, 1, 0, 4'b0000, 1, b[2:0], g(b), 0, (i >= 6), b, 0);
    end
    // full: rejected writes, sticky overflow, clear, set-wins
    cyc(0, 1, 0, 4'b0000, 0, 3'd0, 4'hC, 1, 1, 4'd8, 0);
    cyc(0, 1, 0, 4'b0000, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
    cyc(0, 0, 1, 4'b0000, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
    cyc(0, 1, 1, 4'b0000, 0, 3'd0, 4'hC, 1, 1, 4'd8, 0);
    // read pointer advances to binary 3
    cyc(0, 0, 0, 4'b0010, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
    cyc(0, 0, 1, 4'b0010, 0, 3'd0, 4'hC, 0, 0, 4'd5, 1);
    // refill to level 7
    cyc(0, 1, 0, 4'b0010, 1, 3'd0, 4'hC, 0, 0, 4'd5, 0);
    cyc(0, 1, 0, 4'b0010, 1, 3'd1, 4'hD, 0, 1, 4'd6, 0);
    // simultaneous write and read advance (read binary 4)
    cyc(0, 1, 0, 4'b0110, 1, 3'd2, 4'hF, 0, 1, 4'd7, 0);
    // wrap: read pointer trails so level settles at 2
    cyc(0, 1, 0, 4'hF, 1, 3'd3, 4'hE, 0, 1, 4'd7, 0);
    for (int k = 1; k < 20; k++) begin
      b = 4'(11 + k);
      cyc(0, 1, 0, g(b - 4'd1), 1, b[2:0], g(b), 0, 0, 4'd2, 0);
    end
    cyc(0, 0, 0, 4'h9, 0, 3'd7, 4'h8, 0, 0, 4'd2, 0);
    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge W_CLK);
    #1;
    chk(-2, "queue_drained", 4'(q.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
